// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM encoding, parameter defaults and width helper for the TDC event counter.
// Rev 1.0
`default_nettype none

package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } tdc_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_BITS   = 3;
  localparam int DEF_COUNT_BITS  = 8;
  localparam int DEF_WINDOW_BITS = 10;
  localparam int DEF_HOLDOFF_CYC = 3;

  // Hold-off counter must represent HOLDOFF_CYC; a zero hold-off still needs one bit.
  function automatic int holdoff_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_channel.sv
// tdc_channel: one pulse lane -- synchroniser, rising-edge detect, hold-off, event counter, sticky overflow.
// Rev 1.0. Build option TDC_SATURATE_EN: counter holds at all-ones on overflow instead of wrapping.
`default_nettype none

module tdc_channel
  import tdc_pkg::*;
#(
  parameter int SYNC_BITS   = DEF_SYNC_BITS,
  parameter int COUNT_BITS  = DEF_COUNT_BITS,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  count_en,
  input  logic                  pulse,
  output logic [COUNT_BITS-1:0] count,
  output logic                  ovf
);

  localparam int            HW        = holdoff_width(HOLDOFF_CYC);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC);

  logic [SYNC_BITS-1:0]  sync_q;
  logic                  prev_q;
  logic [HW-1:0]         holdoff_q;
  logic [COUNT_BITS-1:0] count_q;
  logic                  ovf_q;
  logic                  edge_hit;
  logic                  count_full;

  assign edge_hit   = sync_q[SYNC_BITS-1] & ~prev_q & (holdoff_q == '0);
  assign count_full = &count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      holdoff_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_BITS-2:0], pulse};
      prev_q <= sync_q[SYNC_BITS-1];
      // Only accepted edges reload; edges swallowed by the hold-off leave it running down.
      if (edge_hit) begin
        holdoff_q <= HOLD_LOAD;
      end else if (holdoff_q != '0) begin
        holdoff_q <= holdoff_q - HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (count_en && edge_hit) begin
      if (count_full) begin
        ovf_q <= 1'b1;
`ifdef TDC_SATURATE_EN
        count_q <= count_q;
`else
        count_q <= '0;
`endif
      end else begin
        count_q <= count_q + COUNT_BITS'(1);
      end
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/tdc_multi_channel_counter.sv
// tdc_multi_channel_counter: windowed multi-channel event counter with valid/ready result readout.
// Rev 1.0. Build option TDC_SATURATE_EN selects saturating (vs wrapping) channel counters.
`default_nettype none

module tdc_multi_channel_counter
  import tdc_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_BITS   = DEF_SYNC_BITS,
  parameter int COUNT_BITS  = DEF_COUNT_BITS,
  parameter int WINDOW_BITS = DEF_WINDOW_BITS,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WINDOW_BITS-1:0]       window_len,
  input  logic [NUM_CH-1:0]            pulse_in,
  output logic                         ready,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NUM_CH*COUNT_BITS-1:0] res_data,
  output logic [NUM_CH-1:0]            ovf
);

  tdc_state_t             state_q;
  tdc_state_t             state_d;
  logic [WINDOW_BITS-1:0] win_len_q;
  logic [WINDOW_BITS-1:0] win_cnt_q;
  logic                   ch_clear;
  logic                   ch_count_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    ch_clear    = 1'b0;
    ch_count_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy     = 1'b1;
        ch_clear = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        busy        = 1'b1;
        ch_count_en = 1'b1;
        if (win_cnt_q == win_len_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window counter runs 0..win_len_q, giving win_len_q+1 RUN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_len_q <= '0;
      win_cnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start) win_len_q <= window_len;
      if (state_q == ST_CLEAR) begin
        win_cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        win_cnt_q <= win_cnt_q + WINDOW_BITS'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tdc_channel #(
      .SYNC_BITS  (SYNC_BITS),
      .COUNT_BITS (COUNT_BITS),
      .HOLDOFF_CYC(HOLDOFF_CYC)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clear   (ch_clear),
      .count_en(ch_count_en),
      .pulse   (pulse_in[i]),
      .count   (res_data[i*COUNT_BITS +: COUNT_BITS]),
      .ovf     (ovf[i])
    );
  end

endmodule

`default_nettype wire
